pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 65 ++++++
 rtl/hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types, constants and control-word helpers for the five-stage
// pipeline controller and its hazard logic.
package pipe_pkg;

    localparam int REG_W           = 5;
    localparam int MEM_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } pipe_state_e;

    // One bit per pipeline-buffer control; EXE_MEM deliberately has no clear.
    typedef struct packed {
        logic pc_go;
        logic if_id_go;
        logic if_id_clear;
        logic id_exe_go;
        logic id_exe_clear;
        logic exe_mem_go;
        logic mem_wb_go;
        logic mem_wb_clear;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = 8'h00;

    function automatic pipe_ctrl_t ctrl_all_go();
        pipe_ctrl_t c;
        c            = CTRL_NONE;
        c.pc_go      = 1'b1;
        c.if_id_go   = 1'b1;
        c.id_exe_go  = 1'b1;
        c.exe_mem_go = 1'b1;
        c.mem_wb_go  = 1'b1;
        return c;
    endfunction

    function automatic pipe_ctrl_t ctrl_bubble();
        pipe_ctrl_t c;
        c              = CTRL_NONE;
        c.mem_wb_go    = 1'b1;
        c.mem_wb_clear = 1'b1;
        return c;
    endfunction

    function automatic pipe_ctrl_t ctrl_flush(input pipe_ctrl_t base);
        pipe_ctrl_t c;
        c              = base;
        c.if_id_clear  = 1'b1;
        c.id_exe_clear = 1'b1;
        return c;
    endfunction

    // Hold PC and IF/ID, push a bubble into ID/EXE so the load can complete.
    function automatic pipe_ctrl_t ctrl_load_stall(input pipe_ctrl_t base);
        pipe_ctrl_t c;
        c              = base;
        c.pc_go        = 1'b0;
        c.if_id_go     = 1'b0;
        c.id_exe_clear = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EXE.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] exe_rd,
    input  logic             exe_mem_read,
    output logic             load_use
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = id_uses_rs & (id_rs == exe_rd);
    assign rt_hit_s = id_uses_rt & (id_rt == exe_rd);

    // Register zero is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = exe_mem_read & (exe_rd != REG_W'(0)) & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: buffer go/clear generation, memory-wait timeout,
// halt/resume handling and performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] exe_rd,
    input  logic             exe_mem_read,
    input  logic             exe_branch_taken,
    input  logic             mem_halt,
    input  logic             mem_busy,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             if_id_clear,
    output logic             id_exe_go,
    output logic             id_exe_clear,
    output logic             exe_mem_go,
    output logic             mem_wb_go,
    output logic             mem_wb_clear,
    output logic             halted,
    output logic             mem_fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    pipe_state_e       state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_fault_r;
    logic              halted_r;
    logic [CNT_W-1:0]  cycle_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              load_use_s;

    pipe_ctrl_t        run_ctrl_s;
    pipe_state_e       run_next_s;
    logic [WAIT_W-1:0] run_wait_s;
    logic              run_stall_s;
    logic              run_flush_s;

    pipe_ctrl_t        ctrl_s;
    pipe_state_e       state_nxt_s;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic [WAIT_W-1:0] wait_inc_s;
    logic              fault_set_s;
    logic              stall_inc_s;
    logic              flush_inc_s;

    hazard_detect u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .exe_rd       (exe_rd),
        .exe_mem_read (exe_mem_read),
        .load_use     (load_use_s)
    );

    // Normal-operation decision, shared by RUN and by MEM_WAIT once memory is ready.
    always_comb begin
        run_ctrl_s  = ctrl_all_go();
        run_next_s  = ST_RUN;
        run_wait_s  = WAIT_ZERO;
        run_stall_s = 1'b0;
        run_flush_s = 1'b0;
        if (mem_halt) begin
            run_ctrl_s           = CTRL_NONE;
            run_ctrl_s.mem_wb_go = 1'b1;
            run_next_s           = ST_HALT;
        end else if (mem_busy) begin
            // The entry bubble counts as a stall cycle like every later wait cycle.
            run_ctrl_s  = ctrl_bubble();
            run_next_s  = ST_MEM_WAIT;
            run_wait_s  = WAIT_ONE;
            run_stall_s = 1'b1;
        end else if (exe_branch_taken) begin
            run_ctrl_s  = ctrl_flush(ctrl_all_go());
            run_flush_s = 1'b1;
        end else if (load_use_s) begin
            run_ctrl_s  = ctrl_load_stall(ctrl_all_go());
            run_stall_s = 1'b1;
        end else begin
            run_ctrl_s  = ctrl_all_go();
        end
    end

    // Per-state control outputs, next state and counter-increment requests.
    always_comb begin
        ctrl_s      = CTRL_NONE;
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        wait_inc_s  = wait_cnt_r + WAIT_ONE;
        fault_set_s = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        if (!rst_n) begin
            ctrl_s      = CTRL_NONE;
            state_nxt_s = ST_RUN;
            wait_nxt_s  = WAIT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    ctrl_s      = run_ctrl_s;
                    state_nxt_s = run_next_s;
                    wait_nxt_s  = run_wait_s;
                    stall_inc_s = run_stall_s;
                    flush_inc_s = run_flush_s;
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        ctrl_s      = ctrl_bubble();
                        stall_inc_s = 1'b1;
                        wait_nxt_s  = wait_inc_s;
                        if (wait_inc_s == WAIT_LIMIT) begin
                            fault_set_s = 1'b1;
                            state_nxt_s = ST_HALT;
                        end else begin
                            state_nxt_s = ST_MEM_WAIT;
                        end
                    end else begin
                        ctrl_s      = run_ctrl_s;
                        state_nxt_s = run_next_s;
                        wait_nxt_s  = run_wait_s;
                        stall_inc_s = run_stall_s;
                        flush_inc_s = run_flush_s;
                    end
                end
                ST_HALT: begin
                    if (resume && !mem_fault_r) begin
                        // Restart cycle: the halting instruction in MEM_WB is squashed.
                        state_nxt_s = ST_RUN;
                        wait_nxt_s  = WAIT_ZERO;
                        if (exe_branch_taken) begin
                            ctrl_s      = ctrl_flush(ctrl_all_go());
                            flush_inc_s = 1'b1;
                        end else if (load_use_s) begin
                            ctrl_s      = ctrl_load_stall(ctrl_all_go());
                            stall_inc_s = 1'b1;
                        end else begin
                            ctrl_s      = ctrl_all_go();
                        end
                        ctrl_s.mem_wb_clear = 1'b1;
                    end else begin
                        ctrl_s      = CTRL_NONE;
                        state_nxt_s = ST_HALT;
                    end
                end
                default: begin
                    ctrl_s      = CTRL_NONE;
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = WAIT_ZERO;
                end
            endcase
        end
    end

    // Controller state, sticky fault flag and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= WAIT_ZERO;
            mem_fault_r <= 1'b0;
            halted_r    <= 1'b0;
            cycle_cnt_r <= CNT_ZERO;
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            halted_r   <= (state_nxt_s == ST_HALT);
            if (fault_set_s) begin
                mem_fault_r <= 1'b1;
            end
            if (state_r != ST_HALT) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end
            if (stall_inc_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign pc_go        = ctrl_s.pc_go;
    assign if_id_go     = ctrl_s.if_id_go;
    assign if_id_clear  = ctrl_s.if_id_clear;
    assign id_exe_go    = ctrl_s.id_exe_go;
    assign id_exe_clear = ctrl_s.id_exe_clear;
    assign exe_mem_go   = ctrl_s.exe_mem_go;
    assign mem_wb_go    = ctrl_s.mem_wb_go;
    assign mem_wb_clear = ctrl_s.mem_wb_clear;
    assign halted       = halted_r;
    assign mem_fault    = mem_fault_r;
    assign cycle_cnt    = cycle_cnt_r;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: hazards, memory wait/timeout,
// halt/resume and counter behaviour.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs, id_rt, exe_rd;
    logic        id_uses_rs, id_uses_rt, exe_mem_read, exe_branch_taken;
    logic        mem_halt, mem_busy, resume;
    logic        pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear;
    logic        exe_mem_go, mem_wb_go, mem_wb_clear, halted, mem_fault;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [7:0]  ctrl_obs;

    pipe_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .exe_rd(exe_rd), .exe_mem_read(exe_mem_read), .exe_branch_taken(exe_branch_taken),
        .mem_halt(mem_halt), .mem_busy(mem_busy), .resume(resume),
        .pc_go(pc_go), .if_id_go(if_id_go), .if_id_clear(if_id_clear),
        .id_exe_go(id_exe_go), .id_exe_clear(id_exe_clear), .exe_mem_go(exe_mem_go),
        .mem_wb_go(mem_wb_go), .mem_wb_clear(mem_wb_clear),
        .halted(halted), .mem_fault(mem_fault),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear, exe_mem_go, mem_wb_go, mem_wb_clear}
    assign ctrl_obs = {pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
                       exe_mem_go, mem_wb_go, mem_wb_clear};

    localparam logic [7:0] C_NORM   = 8'hD6;
    localparam logic [7:0] C_IDLE   = 8'h00;
    localparam logic [7:0] C_BUB    = 8'h03;
    localparam logic [7:0] C_MHLT   = 8'h02;
    localparam logic [7:0] C_BR     = 8'hFE;
    localparam logic [7:0] C_LU     = 8'h1E;
    localparam logic [7:0] C_RES    = 8'hD7;
    localparam logic [7:0] C_RES_LU = 8'h1F;
    localparam logic [7:0] C_RES_BR = 8'hFF;

    typedef struct {
        string      tag;
        logic [7:0] ctrl;
        logic       halted;
        logic       fault;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned exp_cyc = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] c, input logic h, input logic f);
        exp_t e;
        e.tag    = tag;
        e.ctrl   = c;
        e.halted = h;
        e.fault  = f;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        cmp({e.tag, "/ctrl"},   {24'd0, ctrl_obs},  {24'd0, e.ctrl});
        cmp({e.tag, "/halted"}, {31'd0, halted},    {31'd0, e.halted});
        cmp({e.tag, "/fault"},  {31'd0, mem_fault}, {31'd0, e.fault});
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
        cmp({tag, "/cycle_cnt"}, cycle_cnt, exp_cyc);
        cmp({tag, "/stall_cnt"}, stall_cnt, st);
        cmp({tag, "/flush_cnt"}, flush_cnt, fl);
    endtask

    // One clock: inputs already driven; check outputs mid-cycle, then advance.
    task automatic step(input string tag, input logic [7:0] c, input logic h, input logic f);
        expect_out(tag, c, h, f);
        #2;
        check_out();
        @(posedge clk);
        if (!h) exp_cyc++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; exe_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; exe_mem_read = 1'b0;
        exe_branch_taken = 1'b0; mem_halt = 1'b0; mem_busy = 1'b0; resume = 1'b0;
    endtask

    task automatic set_load_use();
        exe_mem_read = 1'b1; exe_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    endtask

    // Reset asserted for one full clock, checked while held, released at a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        exp_cyc = 0;
        #1;
        expect_out("reset", C_IDLE, 1'b0, 1'b0);
        check_out();
        chk_cnt("reset", 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        @(negedge clk);
        set_load_use();
        mem_halt = 1'b1;
        do_reset();

        step("norm0", C_NORM, 1'b0, 1'b0);
        exe_mem_read = 1'b1; exe_rd = 5'd4; id_rs = 5'd3; id_rt = 5'd5;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        step("nohit", C_NORM, 1'b0, 1'b0);
        chk_cnt("after_norm", 32'd0, 32'd0);

        clear_inputs();
        set_load_use();
        step("lu_rs", C_LU, 1'b0, 1'b0);
        chk_cnt("lu_rs", 32'd1, 32'd0);
        id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        step("lu_rt", C_LU, 1'b0, 1'b0);
        id_uses_rt = 1'b0;
        step("lu_rt_unused", C_NORM, 1'b0, 1'b0);
        id_uses_rt = 1'b1; exe_mem_read = 1'b0;
        step("no_load", C_NORM, 1'b0, 1'b0);
        chk_cnt("lu_rt", 32'd2, 32'd0);

        do_reset();
        set_load_use();
        exe_branch_taken = 1'b1;
        step("br_lu", C_BR, 1'b0, 1'b0);
        chk_cnt("br_lu", 32'd0, 32'd1);
        clear_inputs();
        exe_mem_read = 1'b1; exe_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        step("rd0", C_NORM, 1'b0, 1'b0);
        chk_cnt("rd0", 32'd0, 32'd1);

        clear_inputs();
        mem_busy = 1'b1;
        step("busy1", C_BUB, 1'b0, 1'b0);
        step("busy2", C_BUB, 1'b0, 1'b0);
        step("busy3", C_BUB, 1'b0, 1'b0);
        mem_busy = 1'b0;
        step("busy_done", C_NORM, 1'b0, 1'b0);
        chk_cnt("busy3", 32'd3, 32'd1);
        step("run_again", C_NORM, 1'b0, 1'b0);

        mem_busy = 1'b1;
        step("mw_enter", C_BUB, 1'b0, 1'b0);
        mem_busy = 1'b0; exe_branch_taken = 1'b1;
        step("mw_br", C_BR, 1'b0, 1'b0);
        exe_branch_taken = 1'b0;
        chk_cnt("mw_br", 32'd4, 32'd2);

        mem_busy = 1'b1;
        step("mw_a", C_BUB, 1'b0, 1'b0);
        step("mw_b", C_BUB, 1'b0, 1'b0);
        do_reset();
        step("post_mw_rst", C_NORM, 1'b0, 1'b0);
        chk_cnt("post_mw_rst", 32'd0, 32'd0);

        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step($sformatf("busy_to%0d", i), C_BUB, 1'b0, 1'b0);
        end
        mem_busy = 1'b0;
        step("fault_halt", C_IDLE, 1'b1, 1'b1);
        chk_cnt("fault", 32'd16, 32'd0);
        resume = 1'b1;
        step("resume_blk1", C_IDLE, 1'b1, 1'b1);
        step("resume_blk2", C_IDLE, 1'b1, 1'b1);
        chk_cnt("resume_blk", 32'd16, 32'd0);

        do_reset();
        step("post_fault_rst", C_NORM, 1'b0, 1'b0);
        mem_halt = 1'b1;
        step("mhalt", C_MHLT, 1'b0, 1'b0);
        mem_halt = 1'b0;
        step("halted1", C_IDLE, 1'b1, 1'b0);
        step("halted2", C_IDLE, 1'b1, 1'b0);
        chk_cnt("frozen", 32'd0, 32'd0);
        resume = 1'b1; mem_halt = 1'b1;
        step("resume", C_RES, 1'b1, 1'b0);
        resume = 1'b0; mem_halt = 1'b0;
        step("run_after", C_NORM, 1'b0, 1'b0);
        chk_cnt("run_after", 32'd0, 32'd0);

        mem_halt = 1'b1;
        step("mhalt2", C_MHLT, 1'b0, 1'b0);
        mem_halt = 1'b0;
        step("halted3", C_IDLE, 1'b1, 1'b0);
        resume = 1'b1;
        set_load_use();
        step("resume_lu", C_RES_LU, 1'b1, 1'b0);
        clear_inputs();
        mem_halt = 1'b1;
        step("mhalt3", C_MHLT, 1'b0, 1'b0);
        mem_halt = 1'b0;
        step("halted4", C_IDLE, 1'b1, 1'b0);
        resume = 1'b1; exe_branch_taken = 1'b1;
        set_load_use();
        step("resume_br", C_RES_BR, 1'b1, 1'b0);
        clear_inputs();
        step("run_final", C_NORM, 1'b0, 1'b0);
        chk_cnt("resume_hz", 32'd1, 32'd1);

        cmp("sb_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
